// File: rtl/rs_issue_scheduler.sv
// Issue/completion scheduler: RS1 -> ALU F0/F1, RS2 -> MDU F3, fixed-latency timing, CDB arbitration.
// Optional SCHED_PERF_CNT_EN adds saturating stall / CDB-conflict counters.

module rs_fu_unit #(
   parameter int LAT   = 3,
   parameter int IDX_W = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             issue,
   input  logic [IDX_W-1:0] issue_idx,
   input  logic             grant,
   output logic             idle,
   output logic             done,
   output logic             start,
   output logic [IDX_W-1:0] idx
);
   localparam int CNT_W = (LAT > 1) ? $clog2(LAT) : 1;

   typedef enum logic [1:0] {S_IDLE, S_EXEC, S_DONE} state_t;
   state_t           state;
   logic [CNT_W-1:0] cnt;

   assign idle = (state == S_IDLE);
   assign done = (state == S_DONE);

   // cnt loads LAT-1 with the start pulse, so DONE lands exactly LAT cycles after it
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= S_IDLE;
         cnt   <= '0;
         start <= 1'b0;
         idx   <= '0;
      end else begin
         start <= 1'b0;
         case (state)
            S_IDLE: if (issue) begin
               state <= S_EXEC;
               cnt   <= CNT_W'(LAT - 1);
               start <= 1'b1;
               idx   <= issue_idx;
            end
            S_EXEC: if (cnt == '0) state <= S_DONE;
                    else           cnt   <= cnt - 1'b1;
            S_DONE: if (grant) state <= S_IDLE;
            default: state <= S_IDLE;
         endcase
      end
   end
endmodule

module rs_issue_scheduler #(
   parameter int NUM_ENTRIES = 4,
   parameter int IDX_W       = $clog2(NUM_ENTRIES),
   parameter int ALU_LAT     = 3,
   parameter int MUL_LAT     = 7
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic [NUM_ENTRIES-1:0] rs1_ready,
   input  logic [NUM_ENTRIES-1:0] rs1_alloc,
   input  logic [NUM_ENTRIES-1:0] rs2_ready,
   input  logic [NUM_ENTRIES-1:0] rs2_alloc,
   input  logic                   cdb_ready,
   output logic                   alu0_start,
   output logic [IDX_W-1:0]       alu0_idx,
   output logic                   alu1_start,
   output logic [IDX_W-1:0]       alu1_idx,
   output logic                   mdu_start,
   output logic [IDX_W-1:0]       mdu_idx,
   output logic [2:0]             unit_busy,
   output logic                   cdb_valid,
   output logic [1:0]             cdb_src,
   output logic [IDX_W-1:0]       cdb_idx
`ifdef SCHED_PERF_CNT_EN
  ,output logic [15:0]            stall_cnt,
   output logic [15:0]            cdb_conflict_cnt
`endif
);
   // unit order in all 3-bit vectors: [0]=F0, [1]=F1, [2]=F3
   logic [NUM_ENTRIES-1:0]  rs1_issued, rs2_issued;
   logic [NUM_ENTRIES-1:0]  rs1_cand, rs2_cand, rs1_set, rs2_set;
   logic [IDX_W:0]          rs1_p0, rs1_p1, rs2_p0;
   logic [2:0]              fu_idle, fu_done, fu_start, fu_issue, fu_grant;
   logic [2:0][IDX_W-1:0]   fu_idx, fu_issue_idx;

   // {valid, index} of the lowest set bit
   function automatic logic [IDX_W:0] pick_low(input logic [NUM_ENTRIES-1:0] v);
      logic [IDX_W:0] r;
      r = '0;
      for (int i = NUM_ENTRIES - 1; i >= 0; i--)
         if (v[i]) r = {1'b1, IDX_W'(i)};
      return r;
   endfunction

   function automatic logic [NUM_ENTRIES-1:0] onehot(input logic [IDX_W-1:0] i);
      logic [NUM_ENTRIES-1:0] r;
      r    = '0;
      r[i] = 1'b1;
      return r;
   endfunction

   always_comb begin
      rs1_cand = rs1_ready & ~rs1_issued & ~rs1_alloc;
      rs2_cand = rs2_ready & ~rs2_issued & ~rs2_alloc;
      rs1_p0   = pick_low(rs1_cand);
      rs1_p1   = pick_low(rs1_cand & ~onehot(rs1_p0[IDX_W-1:0]));
      rs2_p0   = pick_low(rs2_cand);

      // F1 takes the second-lowest only when F0 is also taking one this cycle
      fu_issue[0]     = fu_idle[0] & rs1_p0[IDX_W];
      fu_issue_idx[0] = rs1_p0[IDX_W-1:0];
      fu_issue[1]     = fu_idle[1] & (fu_idle[0] ? rs1_p1[IDX_W] : rs1_p0[IDX_W]);
      fu_issue_idx[1] = fu_idle[0] ? rs1_p1[IDX_W-1:0] : rs1_p0[IDX_W-1:0];
      fu_issue[2]     = fu_idle[2] & rs2_p0[IDX_W];
      fu_issue_idx[2] = rs2_p0[IDX_W-1:0];

      rs1_set = (fu_issue[0] ? onehot(fu_issue_idx[0]) : '0)
              | (fu_issue[1] ? onehot(fu_issue_idx[1]) : '0);
      rs2_set = fu_issue[2] ? onehot(fu_issue_idx[2]) : '0;

      fu_grant[2] = cdb_ready & fu_done[2];
      fu_grant[0] = cdb_ready & fu_done[0] & ~fu_done[2];
      fu_grant[1] = cdb_ready & fu_done[1] & ~fu_done[2] & ~fu_done[0];
   end

   // candidates already exclude allocated entries, so alloc always wins over a set
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rs1_issued <= '0;
         rs2_issued <= '0;
      end else begin
         rs1_issued <= (rs1_issued | rs1_set) & ~rs1_alloc;
         rs2_issued <= (rs2_issued | rs2_set) & ~rs2_alloc;
      end
   end

   for (genvar g = 0; g < 3; g++) begin : g_fu
      rs_fu_unit #(
         .LAT   ((g == 2) ? MUL_LAT : ALU_LAT),
         .IDX_W (IDX_W)
      ) u_fu (
         .clk       (clk),
         .rst_n     (rst_n),
         .issue     (fu_issue[g]),
         .issue_idx (fu_issue_idx[g]),
         .grant     (fu_grant[g]),
         .idle      (fu_idle[g]),
         .done      (fu_done[g]),
         .start     (fu_start[g]),
         .idx       (fu_idx[g])
      );
   end

   assign alu0_start = fu_start[0];
   assign alu0_idx   = fu_idx[0];
   assign alu1_start = fu_start[1];
   assign alu1_idx   = fu_idx[1];
   assign mdu_start  = fu_start[2];
   assign mdu_idx    = fu_idx[2];
   assign unit_busy  = ~fu_idle;

   assign cdb_valid = |fu_grant;
   assign cdb_src   = fu_grant[2] ? 2'd2 : (fu_grant[1] ? 2'd1 : 2'd0);
   assign cdb_idx   = fu_grant[2] ? fu_idx[2] :
                      fu_grant[1] ? fu_idx[1] :
                      fu_grant[0] ? fu_idx[0] : '0;

`ifdef SCHED_PERF_CNT_EN
   logic stall_now, conflict_now;
   assign stall_now    = (|rs1_cand & ~fu_idle[0] & ~fu_idle[1]) | (|rs2_cand & ~fu_idle[2]);
   assign conflict_now = (fu_done[0] & fu_done[1]) | (fu_done[0] & fu_done[2])
                       | (fu_done[1] & fu_done[2]);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_cnt        <= '0;
         cdb_conflict_cnt <= '0;
      end else begin
         if (stall_now && stall_cnt != 16'hFFFF)
            stall_cnt <= stall_cnt + 16'd1;
         if (conflict_now && cdb_conflict_cnt != 16'hFFFF)
            cdb_conflict_cnt <= cdb_conflict_cnt + 16'd1;
      end
   end
`else
   // counters compiled out; scheduling behaviour is unchanged
`endif

endmodule
